mult_rr_scheduler: RTL

//   Shares one sequential 8x8 signed shift-add multiplier among NUM_REQ requesters.

---
 rtl/mult_rr_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that time-shares one external sequential 8x8 signed multiplier; optional WAIT watchdog via MULT_SCHED_TIMEOUT_EN.
// Latency: grant, START, >=2 WAIT cycles, then RESP; with an 8-cycle multiplier a request completes in ~11-12 cycles.
// Backpressure: one op in flight; rsp_valid holds until rsp_ready, and no new req_ready is issued before that handshake.
module mult_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [IDX_W-1:0]     rsp_id,
    output logic [15:0]          rsp_product,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic                 mul_start,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_product,
    input  logic                 mul_ready,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 15) begin : g_bad_cfg
        $error("mult_rr_scheduler: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_nxt;
    logic             gnt_found;
    logic [IDX_W:0]   cand;
    logic [IDX_W:0]   nxt_w;
    logic [7:0]       sel_a;
    logic [7:0]       sel_b;

    // Scan from rr_ptr with explicit modulo so non-power-of-2 counts never produce an out-of-range index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        nxt_w = {1'b0, gnt_idx} + (IDX_W+1)'(1);
        if (nxt_w == NUM_REQ_W) begin
            nxt_w = '0;
        end
        gnt_nxt = nxt_w[IDX_W-1:0];
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
            req_ready[i] = rst_n && (state == S_IDLE) && gnt_found && (gnt_idx == IDX_W'(i));
        end
    end

    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);
    // Cycles already spent in WAIT; zero marks the first WAIT cycle where mul_ready may be stale.
    logic [3:0] wait_cnt;
`else
    logic       wait_armed;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
            rsp_err     <= 1'b0;
            wait_cnt    <= '0;
`else
            wait_armed  <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        mul_a     <= sel_a;
                        mul_b     <= sel_b;
                        rsp_id    <= gnt_idx;
                        rr_ptr    <= gnt_nxt;
                        mul_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
                    wait_cnt   <= '0;
`else
                    wait_armed <= 1'b0;
`endif
                end
                S_WAIT: begin
`ifdef MULT_SCHED_TIMEOUT_EN
                    if (mul_ready && (wait_cnt != 4'd0)) begin
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        state       <= S_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`else
                    if (mul_ready && wait_armed) begin
                        rsp_product <= mul_product;
                        state       <= S_RESP;
                    end else begin
                        wait_armed <= 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
`ifdef MULT_SCHED_TIMEOUT_EN
                        rsp_err <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
